modadd_rr_arbiter: RTL and testbench
====================================

Name: modadd_rr_arbiter

Overview:
- Shares one mod-q adder/subtractor (q = 2^255-19) among NUM_REQ requesters, e.g. field-op units in the Curve25519 datapath.
- Round-robin arbitration with valid/ready handshakes on both sides.
- One registered output stage; optional grant lock lets one requester issue back-to-back dependent ops without interleaving.

Parameters:
- NUM_REQ, 4, number of requesters; must be >= 2.
- ID_W, 2, width of rsp_id; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_add  in  NUM_REQ  per-requester op select: 1 = add, 0 = sub.
- req_lock  in  NUM_REQ  per-requester request to keep the grant after this op.
- req_x  in  NUM_REQ*255  operand x; requester i uses bits [i*255 +: 255].
- req_y  in  NUM_REQ*255  operand y; same packing as req_x.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_data  out  255  result.

Behaviour:
- Arithmetic, combinational on the granted operands:
  - add: s = x+y (256-bit); result = s if s < q, else s-q.
  - sub: result = x-y if x >= y, else x-y+q (mod 2^255).
  - Operands must be < q; results for out-of-range operands are unspecified.
- can_accept = !rsp_valid || rsp_ready. req_ready is forced to 0 while rst = 1.
- Arbitration, state ARB:
  - Search order starts at (ptr+1) mod NUM_REQ and wraps.
  - The first requester with valid = 1 is granted.
  - req_ready[g] = can_accept; all other req_ready bits are 0.
- Acceptance (req_valid[g] && req_ready[g]):
  - Next edge: rsp_valid <= 1, rsp_data <= result, rsp_id <= g, ptr <= g.
  - Latency is one cycle from accept to rsp_valid.
- Output drain: if rsp_valid && rsp_ready and no accept this cycle, rsp_valid <= 0. rsp_data and rsp_id hold their last values.
- Drain and accept in the same cycle are legal; throughput is 1 op/cycle.
- Backpressure: while rsp_valid && !rsp_ready, rsp_data, rsp_id and rsp_valid hold stable and all req_ready = 0.
- Request rules: a requester must hold valid, operands, add and lock stable until accepted. Dropping valid before accept is illegal; behaviour in that case is unspecified.
- State machine:
  - ARB -> LOCK when an op is accepted with req_lock[g] = 1. owner <= g.
  - In LOCK, only owner may be granted. If owner drops valid, nobody is granted; the arbiter waits, with no timeout.
  - LOCK -> ARB when an owner op is accepted with req_lock[owner] = 0. That op completes normally and ptr <= owner.
  - LOCK -> LOCK on an owner accept with lock = 1.
- Reset (async, any time, including mid-op or with the output full):
  - rsp_valid = 0, rsp_data = 0, rsp_id = 0.
  - state = ARB; ptr = NUM_REQ-1, so requester 0 has first priority.
  - The in-flight result is discarded.
- No requests: req_ready stays all 0 (no grant), state unchanged.

Optional Feature:
- Macro: MODADD_ARB_STATS_EN.
- When defined, adds two outputs:
  - stat_ops  out  32: counts accepted ops.
  - stat_stall  out  32: counts cycles with any req_valid high and no accept.
  - Both saturate at 2^32-1 and reset to 0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
1. Reset; req0 add, x = 2^255-20, y = 1, rsp_ready = 1.
   - Accepted in cycle 0.
   - Cycle 1: rsp_valid = 1, rsp_id = 0, rsp_data = 0.
2. req2 sub, x = 0, y = 1.
   - rsp_data = 0x7FFF...FFEC (q-1), rsp_id = 2.
   - Also cover x = 5, y = 3 sub: result 2.
3. All four req_valid high from reset, rsp_ready = 1, lock = 0.
   - Grants in cycles 0,1,2,3 go to 0,1,2,3.
   - rsp_id sequence 0,1,2,3 in cycles 1-4, no bubbles.
4. Output full, rsp_ready = 0 for 3 cycles, req1 waiting.
   - req_ready = 0 and rsp_data stable for those 3 cycles.
   - When rsp_ready rises, req1 is accepted in the same cycle.
5. req1 issues 3 ops with lock = 1,1,0 while req2 is continuously valid.
   - Grant order 1,1,1,2.
   - A 2-cycle valid gap by req1 mid-lock gives no grant to req2.
6. Assert rst while rsp_valid = 1 in LOCK.
   - rsp_valid drops before the next edge.
   - After release, requester 0 has priority and the lock is cleared.
   - With MODADD_ARB_STATS_EN defined: stat_ops = 0.

Source files
------------

// File: rtl/modadd_rr_arbiter.sv
// Round-robin arbiter sharing one mod (2^255-19) add/sub unit among NUM_REQ requesters; one registered output stage.
// Optional grant lock keeps one owner granted; define MODADD_ARB_STATS_EN for stat_ops/stat_stall counters.
module modadd_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ-1:0]     req_add,
  input  logic [NUM_REQ-1:0]     req_lock,
  input  logic [NUM_REQ*255-1:0] req_x,
  input  logic [NUM_REQ*255-1:0] req_y,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [254:0]           rsp_data
`ifdef MODADD_ARB_STATS_EN
  ,
  output logic [31:0]            stat_ops,
  output logic [31:0]            stat_stall
`endif
);

  localparam logic [254:0] Q = {{250{1'b1}}, 5'b01101};

  typedef enum logic {ARB, LOCK} state_t;

  state_t          state, state_next;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] owner;
  logic [ID_W-1:0] grant_idx;
  logic            grant_found;
  logic            can_accept;
  logic            accept;
  logic [254:0]    op_x, op_y;
  logic            op_add;
  logic [255:0]    sum;
  logic [254:0]    diff;
  logic [254:0]    result;

  assign can_accept = !rsp_valid || rsp_ready;
  assign accept     = grant_found && can_accept && !rst;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    state_next  = state;
    if (state == LOCK) begin
      // Owner keeps the unit even while idle; other requesters wait.
      if (req_valid[owner]) begin
        grant_found = 1'b1;
        grant_idx   = owner;
      end
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (!grant_found && req_valid[(int'(ptr) + k) % NUM_REQ]) begin
          grant_found = 1'b1;
          grant_idx   = ID_W'((int'(ptr) + k) % NUM_REQ);
        end
      end
    end
    case (state)
      ARB:     if (accept && req_lock[grant_idx])  state_next = LOCK;
      LOCK:    if (accept && !req_lock[grant_idx]) state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && (grant_idx == ID_W'(i));
    end
  end

  assign op_x   = req_x[int'(grant_idx)*255 +: 255];
  assign op_y   = req_y[int'(grant_idx)*255 +: 255];
  assign op_add = req_add[grant_idx];

  // Inputs are < q, so one conditional correction suffices in either direction.
  assign sum    = {1'b0, op_x} + {1'b0, op_y};
  assign diff   = op_x - op_y;
  assign result = op_add ? ((sum >= {1'b0, Q}) ? 255'(sum - {1'b0, Q}) : sum[254:0])
                         : ((op_x >= op_y) ? diff : diff + Q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB;
      ptr       <= ID_W'(NUM_REQ - 1);
      owner     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_data  <= result;
        rsp_id    <= grant_idx;
        ptr       <= grant_idx;
        owner     <= grant_idx;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef MODADD_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops   <= '0;
      stat_stall <= '0;
    end else begin
      if (accept && stat_ops != 32'hFFFF_FFFF) stat_ops <= stat_ops + 32'd1;
      if (|req_valid && !accept && stat_stall != 32'hFFFF_FFFF) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_modadd_rr_arbiter.sv
// Self-checking bench for modadd_rr_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_modadd_rr_arbiter;
  localparam int N = 4;
  localparam logic [255:0] QW = (256'd1 << 255) - 256'd19;
  localparam logic [254:0] Q  = QW[254:0];

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     req_add = '0;
  logic [N-1:0]     req_lock = '0;
  logic [N*255-1:0] req_x = '0;
  logic [N*255-1:0] req_y = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [1:0]       rsp_id;
  logic [254:0]     rsp_data;
`ifdef MODADD_ARB_STATS_EN
  logic [31:0]      stat_ops;
  logic [31:0]      stat_stall;
`endif

  int total = 0;
  int bad = 0;

  modadd_rr_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_add(req_add), .req_lock(req_lock), .req_x(req_x), .req_y(req_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
`ifdef MODADD_ARB_STATS_EN
    , .stat_ops(stat_ops), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [254:0] ref_op(input bit add, input logic [254:0] x, input logic [254:0] y);
    logic [256:0] a;
    if (add) a = ({2'b0, x} + {2'b0, y}) % {1'b0, QW};
    else     a = ({2'b0, x} + {1'b0, QW} - {2'b0, y}) % {1'b0, QW};
    return a[254:0];
  endfunction

  function automatic logic [254:0] rand_operand();
    logic [254:0] v;
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = 255'd1;
      2: v = Q - 255'd1;
      default: begin
        for (int k = 0; k < 7; k++) v[k*32 +: 32] = $urandom();
        v[254:224] = 31'($urandom());
        if (v >= Q) v = v - Q;
      end
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input bit add, input bit lock, input logic [254:0] x, input logic [254:0] y);
    req_add[i]        = add;
    req_lock[i]       = lock;
    req_x[i*255 +: 255] = x;
    req_y[i*255 +: 255] = y;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_add = '0; req_lock = '0; req_x = '0; req_y = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    rsp_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_data !== '0) begin bad++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    tick();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_hold_valid got=%b exp=0", rsp_valid); end
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_add_wrap();
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    set_op(0, 1'b1, 1'b0, Q - 255'd1, 255'd1);
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL add_wrap_ready got=%b exp=0001", req_ready); end
    tick();
    req_valid = '0;
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin bad++; $display("FAIL add_wrap_rsp got v=%b id=%0d exp v=1 id=0", rsp_valid, rsp_id); end
    total++; if (rsp_data !== '0) begin bad++; $display("FAIL add_wrap_data got=%h exp=0", rsp_data); end
    tick();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL add_wrap_drain got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_sub();
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    set_op(2, 1'b0, 1'b0, 255'd0, 255'd1);
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL sub_ready got=%b exp=0100", req_ready); end
    tick();
    total++; if (rsp_id !== 2'd2 || rsp_data !== Q - 255'd1) begin bad++; $display("FAIL sub_borrow got id=%0d data=%h exp id=2 data=%h", rsp_id, rsp_data, Q - 255'd1); end
    set_op(2, 1'b0, 1'b0, 255'd5, 255'd3);
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL sub_again_ready got=%b exp=0100", req_ready); end
    tick();
    req_valid = '0;
    total++; if (rsp_valid !== 1'b1 || rsp_data !== 255'd2) begin bad++; $display("FAIL sub_small got v=%b data=%h exp v=1 data=2", rsp_valid, rsp_data); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_op(i, 1'b1, 1'b0, 255'(i + 10), 255'(i));
    req_valid = 4'hF;
    for (int i = 0; i < N; i++) begin
      exp = 4'(1 << i);
      #1;
      total++; if (req_ready !== exp) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", i, req_ready, exp); end
      tick();
      if (i == N - 1) req_valid = '0;
      total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(i) || rsp_data !== 255'(2*i + 10)) begin
        bad++; $display("FAIL rr_rsp%0d got v=%b id=%0d data=%h exp v=1 id=%0d data=%h", i, rsp_valid, rsp_id, rsp_data, i, 255'(2*i + 10));
      end
    end
    tick();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rr_drain got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    set_op(0, 1'b1, 1'b0, 255'd100, 255'd200);
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL bp_first_ready got=%b exp=0001", req_ready); end
    tick();
    req_valid = 4'b0010;
    set_op(1, 1'b1, 1'b0, 255'd1, 255'd2);
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_data !== 255'd300) begin
        bad++; $display("FAIL bp_hold%0d got rdy=%b v=%b data=%h exp rdy=0000 v=1 data=12c", c, req_ready, rsp_valid, rsp_data);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_release_ready got=%b exp=0010", req_ready); end
    tick();
    req_valid = '0;
    total++; if (rsp_id !== 2'd1 || rsp_data !== 255'd3) begin bad++; $display("FAIL bp_release_rsp got id=%0d data=%h exp id=1 data=3", rsp_id, rsp_data); end
    tick();
  endtask

  task automatic test_lock();
    bit         v1  [6] = '{1, 1, 0, 0, 1, 0};
    bit         lk  [6] = '{1, 1, 0, 0, 0, 0};
    logic [3:0] erdy[6] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0100};
    do_reset();
    rsp_ready = 1'b1;
    set_op(2, 1'b1, 1'b0, 255'd7, 255'd0);
    for (int s = 0; s < 6; s++) begin
      req_valid = {1'b0, 1'b1, v1[s], 1'b0};
      set_op(1, 1'b1, lk[s], 255'(s + 1), 255'd0);
      #1;
      total++; if (req_ready !== erdy[s]) begin bad++; $display("FAIL lock_step%0d_ready got=%b exp=%b", s, req_ready, erdy[s]); end
      tick();
      if (erdy[s] == 4'b0000) begin
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL lock_step%0d_gap got v=%b exp 0", s, rsp_valid); end
      end else if (erdy[s] == 4'b0010) begin
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 255'(s + 1)) begin
          bad++; $display("FAIL lock_step%0d_rsp got v=%b id=%0d data=%h exp v=1 id=1 data=%0d", s, rsp_valid, rsp_id, rsp_data, s + 1);
        end
      end else begin
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 255'd7) begin
          bad++; $display("FAIL lock_step%0d_rsp got v=%b id=%0d data=%h exp v=1 id=2 data=7", s, rsp_valid, rsp_id, rsp_data);
        end
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    set_op(3, 1'b1, 1'b1, 255'd9, 255'd0);
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL rml_ready got=%b exp=1000", req_ready); end
    tick();
    req_valid = '0;
    total++; if (rsp_valid !== 1'b1 || rsp_data !== 255'd9) begin bad++; $display("FAIL rml_full got v=%b data=%h exp v=1 data=9", rsp_valid, rsp_data); end
    rst = 1'b1;
    req_valid = 4'hF;
    #1;
    total++; if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
      bad++; $display("FAIL rml_async got v=%b data=%h id=%0d rdy=%b exp all zero", rsp_valid, rsp_data, rsp_id, req_ready);
    end
`ifdef MODADD_ARB_STATS_EN
    total++; if (stat_ops !== 32'd0) begin bad++; $display("FAIL rml_stat_ops got=%0d exp=0", stat_ops); end
`endif
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_op(i, 1'b1, 1'b0, 255'(i), 255'd0);
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rml_priority got=%b exp=0001", req_ready); end
    tick();
    req_valid = '0;
    total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL rml_rsp_id got=%0d exp=0", rsp_id); end
    tick();
  endtask

  task automatic test_random();
    int           ptr = N - 1;
    bit           locked = 0;
    int           owner = 0;
    bit           mv = 0;
    logic [254:0] md = '0;
    int           mid = 0;
    bit           pv[N];
    bit           padd[N];
    bit           plk[N];
    logic [254:0] px[N];
    logic [254:0] py[N];
    int           ops = 0;
    int           stalls = 0;
    int           g;
    bit           can;
    logic [3:0]   exp;
    do_reset();
    for (int i = 0; i < N; i++) pv[i] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 1) == 1) begin
          pv[i] = 1; padd[i] = 1'($urandom_range(0, 1)); plk[i] = ($urandom_range(0, 3) == 0);
          px[i] = rand_operand(); py[i] = rand_operand();
        end
        req_valid[i] = pv[i];
        set_op(i, padd[i], plk[i], px[i], py[i]);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      g = -1;
      if (locked) begin
        if (pv[owner]) g = owner;
      end else begin
        for (int k = 1; k <= N; k++) if (g < 0 && pv[(ptr + k) % N]) g = (ptr + k) % N;
      end
      can = !mv || rsp_ready;
      exp = (g >= 0 && can) ? 4'(1 << g) : 4'b0000;
      #1;
      total++; if (req_ready !== exp) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp); end
      if (exp != 0) begin
        ops++;
        mv = 1; md = ref_op(padd[g], px[g], py[g]); mid = g;
        ptr = g; owner = g; locked = plk[g]; pv[g] = 0;
      end else begin
        if (req_valid != 0) stalls++;
        if (mv && rsp_ready) mv = 0;
      end
      tick();
      total++; if (rsp_valid !== mv || (mv && (rsp_id !== 2'(mid) || rsp_data !== md))) begin
        bad++; $display("FAIL rand_rsp cyc=%0d got v=%b id=%0d data=%h exp v=%b id=%0d data=%h", cyc, rsp_valid, rsp_id, rsp_data, mv, mid, md);
      end
    end
`ifdef MODADD_ARB_STATS_EN
    total++; if (stat_ops !== 32'(ops)) begin bad++; $display("FAIL rand_stat_ops got=%0d exp=%0d", stat_ops, ops); end
    total++; if (stat_stall !== 32'(stalls)) begin bad++; $display("FAIL rand_stat_stall got=%0d exp=%0d", stat_stall, stalls); end
`endif
    clear_inputs();
    rsp_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_sub();
    test_round_robin();
    test_backpressure();
    test_lock();
    test_reset_mid_lock();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
